cpu_gen2: RTL and testbench
===========================

// Module: cpu_gen2
// PURPOSE
//  Parametrised A-RISC core: accumulator CPU with bus-selected register file, Harvard IRAM/DRAM.
//  Generalises data width, GPR count and address widths. Adds req/ack DRAM handshake with wait
//  states, a hardware CALL/RET stack and a sticky FAULT state for illegal operations.
//  Sits between the instruction RAM, the data RAM (or an interconnect) and the top-level start/idle control.
// PARAMETERS
//  W_DATA      8   datapath/register width (>=4); opr field width
//  NUM_GPR     8   general-purpose registers, addressed 4..NUM_GPR+3
//  W_IADDR     8   IRAM address width; jump/call targets use opr[W_IADDR-1:0]
//  W_DADDR     8   DRAM address width (<=W_DATA); dram_addr = adr[W_DADDR-1:0]
//  STACK_DEPTH 4   return-address stack entries (>=1)
// PORTS
//  clk         in   1          clock, all logic rising-edge
//  rst         in   1          synchronous, active-high reset
//  start       in   1          begin execution at pc=0; sampled only in IDLE
//  idle        out  1          state==IDLE
//  fault       out  1          state==FAULT
//  iram_addr   out  W_IADDR    = pc
//  iram_dout   in   W_DATA+8   {opr[W_DATA], opc[8]}; sync RAM, data valid 1 cycle after addr
//  dram_req    out  1          transaction request; held until dram_ack
//  dram_we     out  1          1=store (STM), 0=load (LDM); stable while dram_req
//  dram_addr   out  W_DADDR    = adr[W_DADDR-1:0]
//  dram_wdata  out  W_DATA     = ac
//  dram_rdata  in   W_DATA     load data, valid in dram_ack cycle
//  dram_ack    in   1          completes request; ignored when dram_req=0
// BEHAVIOUR
//  Reset: state=IDLE, pc/ac/din/adr/gpr/sp=0, idle=1, fault=0, dram_req=0, dram_we=0.
//  Registers: 0=AC 1=DIN 2=OPR(immediate) 3=ADR 4..=GPR. NREG=4+NUM_GPR.
//  FSM: IDLE -start-> FETCH -> EXEC; EXEC -> FETCH | MEM | IDLE(END) | FAULT.
//   MEM -> FETCH on dram_ack; FAULT is sticky until rst (start ignored).
//  Timing: non-memory instr = 2 cycles; LDM/STM = 3 cycles + wait cycles (ack in 1st MEM cycle = 3).
//  pc updates at end of EXEC (non-memory) or on the ack cycle (LDM/STM): pc+1 (wraps), or target.
//  Opcodes: END=0 ADD=1 SUB=2 MUL=3 DV2=4 NOT=5 LDC=6 LDM=7 MVA=8 MVR=9 STM=10 JMZ=11 JMN=12
//   JMP=13 CALL=14 RET=15. R[x] = register addressed by opr.
//  ADD/SUB/MUL: ac <= ac op R[opr], modulo 2^W_DATA (MUL keeps low W_DATA bits).
//  DV2: ac <= signed R[opr]/2, truncating toward zero (-3 -> -1). NOT: ac <= ~R[opr] (bitwise).
//  LDC: ac <= opr. MVA: ac <= R[opr]. MVR: R[opr] <= ac; legal targets 3..NREG-1 only.
//  LDM: dram_req=1, we=0 in MEM; din <= dram_rdata on ack. STM: dram_req=1, we=1, wdata=ac.
//  JMZ/JMN: branch if ac==0 / ac<0 (signed), flags from ac at EXEC. JMP: unconditional.
//  CALL: stack[sp] <= pc+1, sp++, pc <= target. RET: sp--, pc <= stack[sp-1].
//  END: pc <= 0, -> IDLE. idle rises the cycle after EXEC of END.
//  -> FAULT (pc frozen at faulting instr, no register/memory update): opc>15; opr>=NREG for
//   ALU/MVA/MVR read/write; MVR to 0..2; CALL with sp==STACK_DEPTH; RET with sp==0.
//  Within one instruction, register read precedes write (MVA/MVR same-cycle aliasing not possible).
//  rst mid-transaction: dram_req drops the next cycle; a late dram_ack is ignored.
//  dram_ack while not in MEM: ignored.
// CONFIGURATION
//  CPU_GEN2_MUL_EN defined: MUL implemented as above.
//  Undefined: no multiplier synthesised; opcode 3 -> FAULT like an illegal opcode.
// TESTING
//  1. W_DATA=8: LDC 5; MVR 4; LDC 7; MUL 4; END -> gpr0=5, ac=35, idle after 10 cycles from FETCH.
//  2. LDC -3; MVR 4; DV2 4; NOT 0 -> ac=-1 after DV2, ac=0 after NOT; LDC 127; ADD 2(opr=1) -> ac=-128.
//  3. STM/LDM with dram_ack delayed 3 cycles -> dram_req high exactly 4 cycles, din=stored ac, pc advances once.
//  4. STACK_DEPTH=2: CALL,CALL,RET,RET returns correctly; third nested CALL -> fault=1, pc=CALL addr.
//  5. Loop: LDC 3; (loop) SUB with R[opr]=1; JMZ exit; JMP loop -> exits after 3 iterations, ac=0.
//  6. MVR 1, opc=20, RET at sp=0, MUL without CPU_GEN2_MUL_EN -> each faults; start ignored; rst -> idle=1.

Source files
------------

// File: rtl/cpu_gen2_if.sv
// Memory-side bus of the cpu_gen2 core: synchronous instruction RAM port plus
// the req/ack data RAM port. master = core side, slave = memory side.
interface cpu_gen2_if #(
  parameter int W_DATA  = 8,
  parameter int W_IADDR = 8,
  parameter int W_DADDR = 8
);
  logic [W_IADDR-1:0]  iram_addr;
  logic [W_DATA+7:0]   iram_dout;
  logic                dram_req;
  logic                dram_we;
  logic [W_DADDR-1:0]  dram_addr;
  logic [W_DATA-1:0]   dram_wdata;
  logic [W_DATA-1:0]   dram_rdata;
  logic                dram_ack;

  modport master (
    output iram_addr, dram_req, dram_we, dram_addr, dram_wdata,
    input  iram_dout, dram_rdata, dram_ack
  );

  modport slave (
    input  iram_addr, dram_req, dram_we, dram_addr, dram_wdata,
    output iram_dout, dram_rdata, dram_ack
  );
endinterface

// File: rtl/cpu_gen2.sv
// Parametrised accumulator CPU with Harvard IRAM/DRAM, return stack and sticky FAULT.
// Define CPU_GEN2_MUL_EN to build the multiplier; otherwise opcode 3 is illegal.
module cpu_gen2 #(
  parameter int W_DATA      = 8,
  parameter int NUM_GPR     = 8,
  parameter int W_IADDR     = 8,
  parameter int W_DADDR     = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  output logic      idle,
  output logic      fault,
  cpu_gen2_if.master bus
);
  localparam int NREG = 4 + NUM_GPR;
  localparam int W_SP = $clog2(STACK_DEPTH + 1);

  localparam logic [7:0] OP_END = 8'd0,  OP_ADD = 8'd1,  OP_SUB = 8'd2,  OP_MUL = 8'd3;
  localparam logic [7:0] OP_DV2 = 8'd4,  OP_NOT = 8'd5,  OP_LDC = 8'd6,  OP_LDM = 8'd7;
  localparam logic [7:0] OP_MVA = 8'd8,  OP_MVR = 8'd9,  OP_STM = 8'd10, OP_JMZ = 8'd11;
  localparam logic [7:0] OP_JMN = 8'd12, OP_JMP = 8'd13, OP_CALL = 8'd14, OP_RET = 8'd15;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_FAULT} state_t;

  state_t              state_reg, state_next;
  logic [W_IADDR-1:0]  pc_reg, pc_next;
  logic [W_DATA-1:0]   ac_reg, ac_next;
  logic [W_DATA-1:0]   din_reg, din_next;
  logic [W_DATA-1:0]   adr_reg, adr_next;
  logic [W_SP-1:0]     sp_reg, sp_next;
  logic                we_reg, we_next;
  logic [W_DATA-1:0]   gpr_reg [NUM_GPR];
  logic [W_IADDR-1:0]  stack_reg [STACK_DEPTH];
  logic [NUM_GPR-1:0]  gpr_we;
  logic [STACK_DEPTH-1:0] stack_we;
  logic                gpr_wr, stack_wr;

  logic [7:0]          opc;
  logic [W_DATA-1:0]   opr;
  logic [W_IADDR-1:0]  target, ret_addr;
  logic [W_DATA-1:0]   rval, dv2_sum, dv2_val;
  logic                opr_ok, illegal;

  assign opc     = bus.iram_dout[7:0];
  assign opr     = bus.iram_dout[W_DATA+7:8];
  assign target  = opr[W_IADDR-1:0];
  assign opr_ok  = (32'(opr) < NREG);
  // Bias negatives by +1 before the arithmetic shift so division truncates toward zero.
  assign dv2_sum = rval + {{(W_DATA-1){1'b0}}, rval[W_DATA-1]};
  assign dv2_val = $signed(dv2_sum) >>> 1;

  always_comb begin
    rval = '0;
    case (opr)
      W_DATA'(0): rval = ac_reg;
      W_DATA'(1): rval = din_reg;
      W_DATA'(2): rval = opr;
      W_DATA'(3): rval = adr_reg;
      default: begin
        for (int i = 0; i < NUM_GPR; i++)
          if (opr == W_DATA'(i + 4)) rval = gpr_reg[i];
      end
    endcase
  end

  always_comb begin
    ret_addr = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (sp_reg - W_SP'(1) == W_SP'(i)) ret_addr = stack_reg[i];
  end

  always_comb begin
    illegal = 1'b0;
    case (opc)
      OP_ADD, OP_SUB, OP_DV2, OP_NOT, OP_MVA: illegal = !opr_ok;
`ifdef CPU_GEN2_MUL_EN
      OP_MUL:  illegal = !opr_ok;
`endif
      OP_MVR:  illegal = !opr_ok || (opr < W_DATA'(3));
      OP_CALL: illegal = (sp_reg == W_SP'(STACK_DEPTH));
      OP_RET:  illegal = (sp_reg == '0);
      OP_END, OP_LDC, OP_LDM, OP_STM, OP_JMZ, OP_JMN, OP_JMP: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ac_next    = ac_reg;
    din_next   = din_reg;
    adr_next   = adr_reg;
    sp_next    = sp_reg;
    we_next    = we_reg;
    gpr_wr     = 1'b0;
    stack_wr   = 1'b0;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: state_next = S_EXEC;
      S_EXEC: begin
        if (illegal) begin
          state_next = S_FAULT;
        end else begin
          state_next = S_FETCH;
          pc_next    = pc_reg + W_IADDR'(1);
          case (opc)
            OP_END: begin pc_next = '0; state_next = S_IDLE; end
            OP_ADD: ac_next = ac_reg + rval;
            OP_SUB: ac_next = ac_reg - rval;
`ifdef CPU_GEN2_MUL_EN
            OP_MUL: ac_next = ac_reg * rval;
`endif
            OP_DV2: ac_next = dv2_val;
            OP_NOT: ac_next = ~rval;
            OP_LDC: ac_next = opr;
            OP_MVA: ac_next = rval;
            OP_MVR: begin
              if (opr == W_DATA'(3)) adr_next = ac_reg;
              else gpr_wr = 1'b1;
            end
            OP_LDM, OP_STM: begin
              pc_next    = pc_reg;
              we_next    = (opc == OP_STM);
              state_next = S_MEM;
            end
            OP_JMZ: if (ac_reg == '0) pc_next = target;
            OP_JMN: if (ac_reg[W_DATA-1]) pc_next = target;
            OP_JMP: pc_next = target;
            OP_CALL: begin
              stack_wr = 1'b1;
              sp_next  = sp_reg + W_SP'(1);
              pc_next  = target;
            end
            OP_RET: begin
              sp_next = sp_reg - W_SP'(1);
              pc_next = ret_addr;
            end
            default: ;
          endcase
        end
      end
      S_MEM: begin
        if (bus.dram_ack) begin
          if (!we_reg) din_next = bus.dram_rdata;
          pc_next    = pc_reg + W_IADDR'(1);
          state_next = S_FETCH;
        end
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GPR; gi++) begin : g_gpr_we
      assign gpr_we[gi] = gpr_wr && (opr == W_DATA'(gi + 4));
    end
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack_we
      assign stack_we[gi] = stack_wr && (sp_reg == W_SP'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      ac_reg    <= '0;
      din_reg   <= '0;
      adr_reg   <= '0;
      sp_reg    <= '0;
      we_reg    <= 1'b0;
      for (int i = 0; i < NUM_GPR; i++) gpr_reg[i] <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ac_reg    <= ac_next;
      din_reg   <= din_next;
      adr_reg   <= adr_next;
      sp_reg    <= sp_next;
      we_reg    <= we_next;
      for (int i = 0; i < NUM_GPR; i++)
        if (gpr_we[i]) gpr_reg[i] <= ac_reg;
      for (int i = 0; i < STACK_DEPTH; i++)
        if (stack_we[i]) stack_reg[i] <= pc_reg + W_IADDR'(1);
    end
  end

  assign idle           = (state_reg == S_IDLE);
  assign fault          = (state_reg == S_FAULT);
  assign bus.iram_addr  = pc_reg;
  assign bus.dram_req   = (state_reg == S_MEM);
  assign bus.dram_we    = we_reg;
  assign bus.dram_addr  = adr_reg[W_DADDR-1:0];
  assign bus.dram_wdata = ac_reg;
endmodule

// File: tb/tb_cpu_gen2.sv
// Self-checking bench for cpu_gen2: small programs whose results are stored to DRAM
// and compared against a scoreboard of expected {addr,data} writes.
module tb_cpu_gen2;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic idle, fault;

  always #5 clk = ~clk;

  cpu_gen2_if #(.W_DATA(8), .W_IADDR(8), .W_DADDR(8)) bus();

  cpu_gen2 #(.W_DATA(8), .NUM_GPR(8), .W_IADDR(8), .W_DADDR(8), .STACK_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .idle(idle), .fault(fault), .bus(bus)
  );

  logic [15:0] iram [256];
  logic [15:0] iram_q;
  logic [7:0]  dram [256];
  int          ack_delay = 0;
  int          wait_cnt, req_run;
  bit          stray_ack = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          burst_q[$];
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) iram_q <= iram[bus.iram_addr];
  assign bus.iram_dout  = iram_q;
  assign bus.dram_ack   = (bus.dram_req && wait_cnt == ack_delay) || stray_ack;
  assign bus.dram_rdata = dram[bus.dram_addr];

  always @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 0;
      req_run  <= 0;
    end else if (bus.dram_req) begin
      if (bus.dram_ack) begin
        wait_cnt <= 0;
        req_run  <= 0;
        burst_q.push_back(req_run + 1);
        if (bus.dram_we) begin
          dram[bus.dram_addr] <= bus.dram_wdata;
          obs_q.push_back({bus.dram_addr, bus.dram_wdata});
          $display("dram write addr=%0d data=%02h req_cycles=%0d", bus.dram_addr, bus.dram_wdata, req_run + 1);
        end else begin
          $display("dram read  addr=%0d data=%02h req_cycles=%0d", bus.dram_addr, bus.dram_rdata, req_run + 1);
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
        req_run  <= req_run + 1;
      end
    end
  end

  function automatic logic [15:0] ins(input int opc, input int opr);
    return {8'(opr), 8'(opc)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; stray_ack = 1'b0; ack_delay = 0;
    exp_q.delete(); obs_q.delete(); burst_q.delete();
    for (int i = 0; i < 256; i++) begin iram[i] = 16'h0000; dram[i] = 8'h00; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_prog(input int budget, output int cycles, output bit timeout);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1 cycles++;
      if (idle || fault) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b want=1", idle); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b want=0", fault); end
    checks++; if (bus.dram_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", bus.dram_req); end
    checks++; if (bus.dram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", bus.dram_we); end
    checks++; if (bus.iram_addr !== 8'd0) begin failures++; $display("FAIL reset_pc got=%0d want=0", bus.iram_addr); end
  endtask

  task automatic test_mul();
    int cyc; bit to; logic [15:0] e, o;
    do_reset();
    iram[0] = ins(6, 5);  iram[1] = ins(9, 4);  iram[2] = ins(6, 7);
    iram[3] = ins(3, 4);  iram[4] = ins(10, 0); iram[5] = ins(6, 1);
    iram[6] = ins(9, 3);  iram[7] = ins(8, 4);  iram[8] = ins(10, 0);
    iram[9] = ins(0, 0);
`ifdef CPU_GEN2_MUL_EN
    exp_q.push_back({8'd0, 8'd35});
    exp_q.push_back({8'd1, 8'd5});
    run_prog(200, cyc, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL mul_timeout got=%b want=0", to); end
    checks++; if (cyc !== 22) begin failures++; $display("FAIL mul_cycles got=%0d want=22", cyc); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL mul_idle got=%b want=1", idle); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL mul_write got=none want=%04h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL mul_write got=%04h want=%04h", o, e); end end
    end
`else
    run_prog(200, cyc, to);
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL mul_off_fault got=%b want=1", fault); end
    checks++; if (bus.iram_addr !== 8'd3) begin failures++; $display("FAIL mul_off_pc got=%0d want=3", bus.iram_addr); end
`endif
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL mul_extra_writes got=%0d want=0", obs_q.size()); end
  endtask

  task automatic test_dv2();
    int cyc; bit to; logic [15:0] e, o;
    do_reset();
    iram[0]  = ins(6, 8'hFD); iram[1]  = ins(9, 4);  iram[2]  = ins(4, 4);
    iram[3]  = ins(10, 0);    iram[4]  = ins(5, 0);  iram[5]  = ins(9, 5);
    iram[6]  = ins(6, 1);     iram[7]  = ins(9, 3);  iram[8]  = ins(9, 6);
    iram[9]  = ins(8, 5);     iram[10] = ins(10, 0); iram[11] = ins(6, 2);
    iram[12] = ins(9, 3);     iram[13] = ins(6, 127); iram[14] = ins(1, 6);
    iram[15] = ins(10, 0);    iram[16] = ins(4, 0);  iram[17] = ins(10, 0);
    iram[18] = ins(0, 0);
    exp_q.push_back({8'd0, 8'hFF});
    exp_q.push_back({8'd1, 8'h00});
    exp_q.push_back({8'd2, 8'h80});
    exp_q.push_back({8'd2, 8'hC0});
    run_prog(300, cyc, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL dv2_timeout got=%b want=0", to); end
    checks++; if (cyc !== 42) begin failures++; $display("FAIL dv2_cycles got=%0d want=42", cyc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL dv2_write got=none want=%04h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL dv2_write got=%04h want=%04h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL dv2_extra_writes got=%0d want=0", obs_q.size()); end
  endtask

  task automatic test_mem_wait();
    int cyc; bit to; int b; logic [15:0] e, o;
    do_reset();
    ack_delay = 3;
    iram[0] = ins(6, 9);  iram[1] = ins(9, 3);  iram[2]  = ins(6, 8'h5A);
    iram[3] = ins(10, 0); iram[4] = ins(6, 0);  iram[5]  = ins(7, 0);
    iram[6] = ins(6, 10); iram[7] = ins(9, 3);  iram[8]  = ins(8, 1);
    iram[9] = ins(10, 0); iram[10] = ins(0, 0);
    exp_q.push_back({8'd9, 8'h5A});
    exp_q.push_back({8'd10, 8'h5A});
    run_prog(300, cyc, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL mem_timeout got=%b want=0", to); end
    checks++; if (cyc !== 34) begin failures++; $display("FAIL mem_cycles got=%0d want=34", cyc); end
    checks++; if (burst_q.size() != 3) begin failures++; $display("FAIL mem_transactions got=%0d want=3", burst_q.size()); end
    while (burst_q.size() > 0) begin
      b = burst_q.pop_front();
      checks++; if (b !== 4) begin failures++; $display("FAIL mem_req_cycles got=%0d want=4", b); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL mem_write got=none want=%04h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL mem_write got=%04h want=%04h", o, e); end end
    end
  endtask

  task automatic test_stack();
    int cyc; bit to; logic [15:0] e, o;
    do_reset();
    iram[0]  = ins(14, 10); iram[1]  = ins(6, 0);  iram[2]  = ins(9, 3);
    iram[3]  = ins(6, 8'h11); iram[4] = ins(10, 0); iram[5] = ins(0, 0);
    iram[10] = ins(14, 20); iram[11] = ins(6, 2);  iram[12] = ins(9, 3);
    iram[13] = ins(6, 8'h22); iram[14] = ins(10, 0); iram[15] = ins(15, 0);
    iram[20] = ins(6, 1);   iram[21] = ins(9, 3);  iram[22] = ins(6, 8'h33);
    iram[23] = ins(10, 0);  iram[24] = ins(15, 0);
    exp_q.push_back({8'd1, 8'h33});
    exp_q.push_back({8'd2, 8'h22});
    exp_q.push_back({8'd0, 8'h11});
    run_prog(300, cyc, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL stack_timeout got=%b want=0", to); end
    checks++; if (cyc !== 37) begin failures++; $display("FAIL stack_cycles got=%0d want=37", cyc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL stack_write got=none want=%04h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL stack_write got=%04h want=%04h", o, e); end end
    end
    // Third nested call overflows a two-entry stack.
    do_reset();
    iram[0] = ins(14, 10); iram[10] = ins(14, 20); iram[20] = ins(14, 30);
    run_prog(100, cyc, to);
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL stack_ovf_fault got=%b want=1", fault); end
    checks++; if (bus.iram_addr !== 8'd20) begin failures++; $display("FAIL stack_ovf_pc got=%0d want=20", bus.iram_addr); end
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    checks++; if (fault !== 1'b1 || idle !== 1'b0) begin failures++; $display("FAIL fault_sticky got=%b%b want=10", fault, idle); end
    do_reset();
    #1;
    checks++; if (idle !== 1'b1 || fault !== 1'b0) begin failures++; $display("FAIL fault_rst got=%b%b want=01", idle, fault); end
  endtask

  task automatic test_loop();
    int cyc; bit to; logic [15:0] e, o;
    do_reset();
    stray_ack = 1'b1;
    iram[0] = ins(6, 1);  iram[1] = ins(9, 4);   iram[2]  = ins(6, 3);
    iram[3] = ins(2, 4);  iram[4] = ins(11, 6);  iram[5]  = ins(13, 3);
    iram[6] = ins(10, 0); iram[7] = ins(2, 4);   iram[8]  = ins(12, 10);
    iram[9] = ins(0, 0);  iram[10] = ins(10, 0); iram[11] = ins(0, 0);
    exp_q.push_back({8'd0, 8'h00});
    exp_q.push_back({8'd0, 8'hFF});
    run_prog(300, cyc, to);
    stray_ack = 1'b0;
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL loop_timeout got=%b want=0", to); end
    checks++; if (cyc !== 34) begin failures++; $display("FAIL loop_cycles got=%0d want=34", cyc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL loop_write got=none want=%04h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL loop_write got=%04h want=%04h", o, e); end end
    end
  endtask

  task automatic test_faults();
    int cyc; bit to;
    int bad_opc [7] = '{9, 9, 20, 15, 8, 1, 16};
    int bad_opr [7] = '{1, 2, 0, 0, 12, 255, 0};
    for (int k = 0; k < 7; k++) begin
      do_reset();
      iram[0] = ins(6, 5);
      iram[1] = ins(bad_opc[k], bad_opr[k]);
      iram[2] = ins(10, 0);
      run_prog(100, cyc, to);
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL fault%0d_state got=%b want=1", k, fault); end
      checks++; if (bus.iram_addr !== 8'd1) begin failures++; $display("FAIL fault%0d_pc got=%0d want=1", k, bus.iram_addr); end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL fault%0d_writes got=%0d want=0", k, obs_q.size()); end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_mul();
    test_dv2();
    test_mem_wait();
    test_stack();
    test_loop();
    test_faults();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
